// File: rtl/romcode_bram_arbiter.sv
// Two-requester arbiter for the single-port romcode BRAM: round-robin or fixed
// priority, bounded lock bursts, and read data steered back to the issuing requester.
module romcode_bram_arbiter #(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [3:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [3:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [31:0]       romcode_Addr_A,
    output logic              romcode_EN_A,
    output logic [3:0]        romcode_WEN_A,
    output logic [31:0]       romcode_Din_A,
    input  logic [31:0]       romcode_Dout_A,
    output logic              romcode_Clk_A,
    output logic              romcode_Rst_A
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PIPE_D = RD_LAT + 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state, state_nxt;
    logic              last_owner, last_nxt;
    logic              force_q, force_nxt;
    logic [CNT_W-1:0]  lock_cnt, cnt_nxt;
    logic              gnt0_c, gnt1_c;
    logic [1:0]        req;
    logic              pick, pick_lock, other_req, forced_hit;

    logic [3:0]        cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W+1:0] cmd_baddr;
    logic [31:0]       cmd_wdata;
    logic              xfer, rd_xfer;

    logic [PIPE_D-1:0] pipe0, pipe1;
    logic [31:0]       hold0, hold1;

    assign req = {m1_req, m0_req};

    // Arbitration and ownership tracking
    always_comb begin
        state_nxt  = state;
        last_nxt   = last_owner;
        force_nxt  = 1'b0;
        cnt_nxt    = lock_cnt;
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        forced_hit = 1'b0;
        pick       = 1'b0;
        pick_lock  = 1'b0;
        other_req  = 1'b0;
        if (state == OWN0 && m0_req) begin
            gnt0_c   = 1'b1;
            last_nxt = 1'b0;
            if (lock_cnt >= CNT_W'(LOCK_MAX)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                force_nxt = m1_req;
            end else if (m0_lock) begin
                if (m1_req) cnt_nxt = lock_cnt + CNT_W'(1);
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end else if (state == OWN1 && m1_req) begin
            gnt1_c   = 1'b1;
            last_nxt = 1'b1;
            if (lock_cnt >= CNT_W'(LOCK_MAX)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                force_nxt = m0_req;
            end else if (m1_lock) begin
                if (m0_req) cnt_nxt = lock_cnt + CNT_W'(1);
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end else begin
            // Idle decision, also taken the same cycle an owner drops its request
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            forced_hit = (state == IDLE) && force_q && req[~last_owner];
            if (forced_hit)
                pick = ~last_owner;
            else if (&req)
                pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner;
            else
                pick = req[1];
            pick_lock = pick ? m1_lock : m0_lock;
            other_req = pick ? m0_req : m1_req;
            if (|req) begin
                gnt0_c   = ~pick;
                gnt1_c   = pick;
                last_nxt = pick;
                if (pick_lock && !forced_hit) begin
                    state_nxt = pick ? OWN1 : OWN0;
                    cnt_nxt   = other_req ? CNT_W'(1) : '0;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            force_q    <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_nxt;
            force_q    <= force_nxt;
            lock_cnt   <= cnt_nxt;
        end
    end

    assign m0_gnt = gnt0_c & ~ap_rst;
    assign m1_gnt = gnt1_c & ~ap_rst;

    assign xfer      = gnt0_c | gnt1_c;
    assign cmd_we    = gnt1_c ? m1_we    : m0_we;
    assign cmd_addr  = gnt1_c ? m1_addr  : m0_addr;
    assign cmd_wdata = gnt1_c ? m1_wdata : m0_wdata;
    assign cmd_baddr = {cmd_addr, 2'b00};
    assign rd_xfer   = xfer && (cmd_we == 4'b0000);

    // Registered BRAM command port
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            romcode_EN_A   <= 1'b0;
            romcode_WEN_A  <= 4'b0000;
            romcode_Addr_A <= '0;
            romcode_Din_A  <= '0;
        end else if (xfer) begin
            romcode_EN_A   <= 1'b1;
            romcode_WEN_A  <= cmd_we;
            romcode_Addr_A <= 32'(cmd_baddr);
            romcode_Din_A  <= cmd_wdata;
        end else begin
            romcode_EN_A   <= 1'b0;
            romcode_WEN_A  <= 4'b0000;
        end
    end

    // Owner tags ride alongside the BRAM read latency
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            pipe0 <= '0;
            pipe1 <= '0;
        end else begin
            pipe0 <= {pipe0[PIPE_D-2:0], rd_xfer & gnt0_c};
            pipe1 <= {pipe1[PIPE_D-2:0], rd_xfer & gnt1_c};
        end
    end

    assign m0_rvalid = pipe0[PIPE_D-1];
    assign m1_rvalid = pipe1[PIPE_D-1];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (m0_rvalid) hold0 <= romcode_Dout_A;
            if (m1_rvalid) hold1 <= romcode_Dout_A;
        end
    end

    assign m0_rdata = m0_rvalid ? romcode_Dout_A : hold0;
    assign m1_rdata = m1_rvalid ? romcode_Dout_A : hold1;

    assign romcode_Clk_A = ap_clk;
    assign romcode_Rst_A = ap_rst;

endmodule

// File: tb/tb_romcode_bram_arbiter.sv
// Directed bench for romcode_bram_arbiter with a behavioural 1-cycle BRAM;
// a second FIXED_PRIO instance shares the inputs for the lock-limit scenario.
module tb_romcode_bram_arbiter;

    localparam int unsigned AW = 30;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          m0_req, m0_lock, m1_req, m1_lock;
    logic [3:0]    m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic [31:0]   r_addr, r_din, r_dout;
    logic          r_en, r_clk, r_rst;
    logic [3:0]    r_wen;

    logic          f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid;
    logic [31:0]   f_m0_rdata, f_m1_rdata, f_addr, f_din;
    logic          f_en, f_clk, f_rst;
    logic [3:0]    f_wen;

    logic [31:0]   mem [0:255];
    logic          pl_en;
    logic [7:0]    pl_idx;
    logic [31:0]   pl_val;

    int checks;
    int failures;

    always #5 ap_clk = ~ap_clk;

    romcode_bram_arbiter #(.ADDR_W(AW), .RD_LAT(1), .FIXED_PRIO(0), .LOCK_MAX(4)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .romcode_Addr_A(r_addr), .romcode_EN_A(r_en), .romcode_WEN_A(r_wen),
        .romcode_Din_A(r_din), .romcode_Dout_A(r_dout),
        .romcode_Clk_A(r_clk), .romcode_Rst_A(r_rst)
    );

    romcode_bram_arbiter #(.ADDR_W(AW), .RD_LAT(1), .FIXED_PRIO(1), .LOCK_MAX(4)) dut_fixed (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
        .romcode_Addr_A(f_addr), .romcode_EN_A(f_en), .romcode_WEN_A(f_wen),
        .romcode_Din_A(f_din), .romcode_Dout_A(r_dout),
        .romcode_Clk_A(f_clk), .romcode_Rst_A(f_rst)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    // Read-first BRAM model, one cycle read latency, plus a bench preload port
    always @(posedge ap_clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (r_en) begin
            if (r_wen == 4'b0000) r_dout <= mem[r_addr[9:2]];
            else mem[r_addr[9:2]] <= merge(mem[r_addr[9:2]], r_din, r_wen);
        end
    end

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        tick();
        pl_en  = 1'b0;
    endtask

    task automatic idle_inputs;
        m0_req = 1'b0; m0_lock = 1'b0; m0_we = 4'b0000; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 4'b0000; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic reset_dut;
        idle_inputs();
        ap_rst = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;
    endtask

    task automatic test_reset;
        ap_rst = 1'b1;
        m0_req = 1'b1;
        m1_req = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (r_en !== 1'b0 || r_wen !== 4'b0000 || r_addr !== 32'h0 || r_din !== 32'h0) begin
            failures++;
            $display("FAIL reset_bram: en=%b wen=%b addr=%h din=%h want 0", r_en, r_wen, r_addr, r_din);
        end
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt: m0=%b m1=%b want 0 0", m0_gnt, m1_gnt);
        end
        checks++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd: rv=%b%b d0=%h d1=%h want 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
        checks++;
        if (r_rst !== 1'b1 || f_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_passthru: got %b %b want 1", r_rst, f_rst);
        end
        idle_inputs();
        tick();
        for (int i = 0; i < 256; i++) preload(8'(i), 32'hC0DE_0000 | 32'(i));
    endtask

    task automatic test_single_read;
        preload(8'h10, 32'hDEAD_BEEF);
        reset_dut();
        m0_req = 1'b1; m0_addr = 30'h10;
        @(negedge ap_clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL single_gnt: m0=%b m1=%b want 1 0", m0_gnt, m1_gnt);
        end
        tick();
        m0_req = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (r_en !== 1'b1 || r_addr !== 32'h40 || r_wen !== 4'b0000 || m0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_issue: en=%b addr=%h wen=%b rv=%b want 1 40 0 0", r_en, r_addr, r_wen, m0_rvalid);
        end
        tick();
        @(negedge ap_clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_rvalid !== 1'b0 || r_en !== 1'b0) begin
            failures++;
            $display("FAIL single_return: rv0=%b d=%h rv1=%b en=%b want 1 deadbeef 0 0",
                     m0_rvalid, m0_rdata, m1_rvalid, r_en);
        end
        tick();
        @(negedge ap_clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_hold: rv0=%b d=%h want 0 deadbeef", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_write_then_read;
        preload(8'h05, 32'hAAAA_AAAA);
        m1_req = 1'b1; m1_we = 4'b0011; m1_addr = 30'h5; m1_wdata = 32'h1234_5678;
        @(negedge ap_clk);
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            failures++;
            $display("FAIL wr_gnt: m1=%b m0=%b want 1 0", m1_gnt, m0_gnt);
        end
        tick();
        m1_req = 1'b0; m1_we = 4'b0000;
        m0_req = 1'b1; m0_addr = 30'h5;
        @(negedge ap_clk);
        checks++;
        if (m0_gnt !== 1'b1 || r_en !== 1'b1 || r_wen !== 4'b0011 || r_addr !== 32'h14 ||
            r_din !== 32'h1234_5678) begin
            failures++;
            $display("FAIL wr_issue: g0=%b en=%b wen=%b addr=%h din=%h want 1 1 3 14 12345678",
                     m0_gnt, r_en, r_wen, r_addr, r_din);
        end
        tick();
        m0_req = 1'b0;
        tick();
        @(negedge ap_clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hAAAA_5678 || m1_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_readback: rv0=%b d=%h rv1=%b want 1 aaaa5678 0", m0_rvalid, m0_rdata, m1_rvalid);
        end
        tick();
    endtask

    task automatic test_round_robin;
        logic        own [0:5];
        logic [31:0] dat [0:5];
        logic        e0;
        reset_dut();
        m0_req = 1'b1; m0_addr = 30'h20;
        m1_req = 1'b1; m1_addr = 30'h40;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            @(negedge ap_clk);
            if (c < 6) begin
                e0 = (c % 2 == 0);
                own[c] = ~e0;
                dat[c] = 32'hC0DE_0000 | 32'(e0 ? m0_addr : m1_addr);
                checks++;
                if (m0_gnt !== e0 || m1_gnt !== ~e0) begin
                    failures++;
                    $display("FAIL rr_gnt[%0d]: m0=%b m1=%b want %b %b", c, m0_gnt, m1_gnt, e0, ~e0);
                end
            end
            if (c >= 1 && c <= 6) begin
                checks++;
                if (r_en !== 1'b1) begin
                    failures++;
                    $display("FAIL rr_en[%0d]: got %b want 1", c, r_en);
                end
            end
            if (c >= 2) begin
                checks++;
                if (m0_rvalid !== ~own[c-2] || m1_rvalid !== own[c-2] ||
                    (own[c-2] ? m1_rdata : m0_rdata) !== dat[c-2]) begin
                    failures++;
                    $display("FAIL rr_ret[%0d]: rv=%b%b d0=%h d1=%h want owner m%0d data %h",
                             c, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata, own[c-2], dat[c-2]);
                end
            end
            tick();
            if (c < 6) begin
                if (own[c]) m1_addr = m1_addr + AW'(1);
                else m0_addr = m0_addr + AW'(1);
            end
        end
    endtask

    task automatic test_lock_limit;
        logic e0;
        reset_dut();
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 30'h60;
        m1_req = 1'b1; m1_addr = 30'h50;
        for (int c = 0; c < 6; c++) begin
            @(negedge ap_clk);
            e0 = (c < 5);
            checks++;
            if (m0_gnt !== e0 || m1_gnt !== ~e0) begin
                failures++;
                $display("FAIL lock_rr[%0d]: m0=%b m1=%b want %b %b", c, m0_gnt, m1_gnt, e0, ~e0);
            end
            checks++;
            if (f_m0_gnt !== e0 || f_m1_gnt !== ~e0) begin
                failures++;
                $display("FAIL lock_fixed[%0d]: m0=%b m1=%b want %b %b", c, f_m0_gnt, f_m1_gnt, e0, ~e0);
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_owner_release;
        reset_dut();
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 30'h1;
        @(negedge ap_clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rel_take: m0=%b want 1", m0_gnt);
        end
        tick();
        m0_req = 1'b0; m0_lock = 1'b0;
        m1_req = 1'b1; m1_addr = 30'h2;
        @(negedge ap_clk);
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            failures++;
            $display("FAIL rel_handover: m1=%b m0=%b want 1 0", m1_gnt, m0_gnt);
        end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_midop;
        reset_dut();
        m0_req = 1'b1; m0_addr = 30'h21;
        @(negedge ap_clk);
        checks++;
        if (m0_gnt !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt: m0=%b want 1", m0_gnt);
        end
        tick();
        m0_req = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        checks++;
        if (r_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_en_drop: en=%b want 0", r_en);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge ap_clk);
            checks++;
            if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_rvalid[%0d]: rv0=%b rv1=%b want 0 0", c, m0_rvalid, m1_rvalid);
            end
        end
        tick();
        ap_rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL mid_first_tie: m0=%b m1=%b want 1 0", m0_gnt, m1_gnt);
        end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pl_en    = 1'b0;
        pl_idx   = '0;
        pl_val   = '0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_then_read();
        test_round_robin();
        test_lock_limit();
        test_owner_release();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/romcode_bram_arbiter.md
Name: romcode_bram_arbiter

Overview:
- Shares the single-port romcode BRAM (the romcode_* port that backs the SPI flash model) between two requesters.
- Requester m0 is the flash-model fetch path; requester m1 is the backdoor loader/debug port that patches or reads ROM contents during simulation and FPGA bring-up.
- Provides round-robin or fixed-priority arbitration, bounded burst locking, and per-requester read-return steering.

Parameters:
ADDR_W, 30, word-address width of each requester (byte address = word address << 2).
RD_LAT, 1, BRAM read latency in cycles from the EN-sampled edge to valid Dout_A; legal range 1..3.
FIXED_PRIO, 0, arbitration mode: 0 = round-robin, 1 = m0 always wins ties.
LOCK_MAX, 16, maximum consecutive locked grants while the other requester waits; legal range 2..255.

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous active-high reset
m0_req  in  1  m0 command valid
m0_lock  in  1  m0 requests to keep ownership for its next command
m0_we  in  4  m0 byte write strobes; 0 means read
m0_addr  in  ADDR_W  m0 word address
m0_wdata  in  32  m0 write data
m0_gnt  out  1  m0 command accepted this cycle
m0_rvalid  out  1  m0 read data valid
m0_rdata  out  32  m0 read data
m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  (same directions, widths and meanings for m1)
romcode_Addr_A  out  32  BRAM byte address
romcode_EN_A  out  1  BRAM enable
romcode_WEN_A  out  4  BRAM byte write enables
romcode_Din_A  out  32  BRAM write data
romcode_Dout_A  in  32  BRAM read data
romcode_Clk_A  out  1  BRAM clock; equals ap_clk
romcode_Rst_A  out  1  BRAM reset; equals ap_rst

Behaviour:
- Reset (asynchronous, active-high):
  - romcode_EN_A=0, romcode_WEN_A=0, romcode_Addr_A=0, romcode_Din_A=0.
  - m*_gnt=0 while ap_rst is high; m*_rvalid=0; m*_rdata=0.
  - State IDLE, last_owner=m1 so m0 wins the first tie, lock counter=0, read pipeline cleared.
- Handshake:
  - A command transfers in cycle t when req&gnt.
  - gnt is combinational from req, state and counters; at most one gnt is high per cycle.
  - A requester holds req, we, addr and wdata stable until granted.
- Command issue: the transferred command is registered and drives romcode_* in cycle t+1.
  - EN=1 for exactly one cycle per command.
  - WEN=we; Addr={zero-ext addr,2'b00}; Din=wdata.
  - In idle cycles, EN=0 and WEN=0.
  - Back-to-back grants give continuous EN.
- Read return:
  - For a read accepted at t, the owner tag is shifted through an (RD_LAT+1)-deep pipeline.
  - rvalid pulses in cycle t+1+RD_LAT; default latency is 2.
  - m*_rdata = Dout_A while that requester's rvalid is high, otherwise it holds its last value.
  - Writes produce no rvalid. Reads and writes may interleave freely; returns arrive in order.
- State machine: IDLE, OWN0, OWN1.
  - IDLE: grant by mode. Round-robin grants the requester that is not last_owner on a tie; FIXED_PRIO=1 grants m0. A lone requester wins.
  - Go to OWNx if the granted command has lock=1; otherwise stay in IDLE and update last_owner.
  - OWNx: only mx can be granted. Stay in OWNx while each granted command has lock=1.
  - OWNx exits to IDLE when the owner's req is low or its command has lock=0; that command is still granted.
- Lock counter:
  - Increments per grant in OWNx while the other requester's req is high; clears on leaving OWNx.
  - When it reaches LOCK_MAX, the next owner command is still granted, then the FSM returns to IDLE.
  - It then grants the waiting requester in the following cycle regardless of FIXED_PRIO and ignores that requester's lock for that one grant.
- Simultaneous events:
  - Owner deasserts req while the other requester asserts it: the other requester is granted in the same cycle (IDLE decision applied combinationally).
  - Both requesters read the same address back-to-back: each gets its own rvalid, one cycle apart.
- Reset mid-operation: in-flight reads are discarded with no rvalid; EN drops immediately.

Test Plan:
- Single m0 read of addr 0x10 after preloading word 0xDEADBEEF: gnt at t, Addr=0x40 with EN at t+1, m0_rvalid at t+2 with rdata 0xDEADBEEF; m1_rvalid stays 0.
- m1 writes we=4'b0011, data 0x12345678 to addr 5, then m0 reads addr 5 with prior content 0xAAAAAAAA: m0_rdata=0xAAAA5678 at the expected cycle.
- Round-robin with m0 and m1 both issuing continuous unlocked reads: grants alternate m0,m1,m0,...; EN stays high every cycle; return order matches grant order.
- LOCK_MAX=4, m1 requesting while m0 issues locked reads: m0 receives exactly 5 consecutive grants (4 counted plus the final one), then m1 is granted next cycle; rerun with FIXED_PRIO=1 and expect the same result.
- ap_rst asserted one cycle after a read is granted: no rvalid appears and EN=0 immediately; after release, the first tie goes to m0.
